// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter.
// Response-tag encodings, default geometry and a saturating helper.
package dmem_arbiter_pkg;

    localparam int DARB_DATA_WIDTH = 16;
    localparam int DARB_MEM_SIZE   = 1024;
    localparam int DARB_ADDR_WIDTH = $clog2(DARB_MEM_SIZE);
    localparam int DARB_MAX_WAIT   = 4;
    localparam int DARB_CNT_WIDTH  = 8;

    typedef enum logic [1:0] {
        DARB_IDLE   = 2'b00,
        DARB_RESP_P = 2'b01,
        DARB_RESP_D = 2'b10
    } darb_state_e;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/dmem_arbiter_age_ctr.sv
// Debug-port age counter: counts cycles a D request waits.
// Saturates at MAX_WAIT; force_d_o asks for a forced D slot.
module dmem_arbiter_age_ctr
    import dmem_arbiter_pkg::*;
#(
    parameter int MAX_WAIT = DARB_MAX_WAIT
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_req_i,
    input  logic d_gnt_i,
    output logic force_d_o
);

    localparam logic [DARB_CNT_WIDTH-1:0] LIMIT =
        DARB_CNT_WIDTH'(MAX_WAIT);

    logic [DARB_CNT_WIDTH-1:0] wait_cnt_q;
    logic [DARB_CNT_WIDTH-1:0] wait_cnt_d;

    // Next count: clear when served or idle, else climb to the limit.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (!d_req_i || d_gnt_i)
            wait_cnt_d = '0;
        else if (wait_cnt_q != LIMIT)
            wait_cnt_d = wait_cnt_q + 1'b1;
    end

    // Count register, advanced on the pipeline's falling edge.
    always_ff @(negedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            wait_cnt_q <= '0;
        else
            wait_cnt_q <= wait_cnt_d;
    end

    assign force_d_o = (wait_cnt_q == LIMIT);

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: MEM stage (P) has priority over debug (D).
// Optional DMEM_ARB_STATS_EN adds O_CONFLICT_CNT.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = DARB_ADDR_WIDTH,
    parameter int DATA_WIDTH = DARB_DATA_WIDTH,
    parameter int MAX_WAIT   = DARB_MAX_WAIT
) (
    input  logic                  I_CLOCK,
    input  logic                  I_RESET_N,
    input  logic                  I_P_REQ,
    input  logic                  I_P_WE,
    input  logic [ADDR_WIDTH-1:0] I_P_ADDR,
    input  logic [DATA_WIDTH-1:0] I_P_WDATA,
    output logic                  O_P_GNT,
    output logic                  O_P_STALL,
    output logic                  O_P_RVALID,
    output logic [DATA_WIDTH-1:0] O_P_RDATA,
    input  logic                  I_D_REQ,
    input  logic                  I_D_WE,
    input  logic [ADDR_WIDTH-1:0] I_D_ADDR,
    input  logic [DATA_WIDTH-1:0] I_D_WDATA,
    output logic                  O_D_GNT,
    output logic                  O_D_RVALID,
    output logic [DATA_WIDTH-1:0] O_D_RDATA,
    output logic                  O_MEM_EN,
    output logic                  O_MEM_WE,
    output logic [ADDR_WIDTH-1:0] O_MEM_ADDR,
    output logic [DATA_WIDTH-1:0] O_MEM_WDATA,
`ifdef DMEM_ARB_STATS_EN
    output logic [15:0]           O_CONFLICT_CNT,
`endif
    input  logic [DATA_WIDTH-1:0] I_MEM_RDATA
);

    darb_state_e state_q;
    logic        force_d;
    logic        p_gnt;
    logic        d_gnt;

    dmem_arbiter_age_ctr #(
        .MAX_WAIT (MAX_WAIT)
    ) u_age_ctr (
        .clk_i     (I_CLOCK),
        .rst_ni    (I_RESET_N),
        .d_req_i   (I_D_REQ),
        .d_gnt_i   (d_gnt),
        .force_d_o (force_d)
    );

    // D wins only when forced or P is quiet; nothing granted in reset.
    assign d_gnt = I_RESET_N && I_D_REQ && (force_d || !I_P_REQ);
    assign p_gnt = I_RESET_N && I_P_REQ && !d_gnt;

    assign O_P_GNT   = p_gnt;
    assign O_D_GNT   = d_gnt;
    assign O_P_STALL = I_RESET_N && I_P_REQ && !p_gnt;
    assign O_MEM_EN  = p_gnt || d_gnt;

    // Route the granted port's command onto the memory bus.
    always_comb begin
        O_MEM_WE    = 1'b0;
        O_MEM_ADDR  = '0;
        O_MEM_WDATA = '0;
        unique case (1'b1)
            p_gnt: begin
                O_MEM_WE    = I_P_WE;
                O_MEM_ADDR  = I_P_ADDR;
                O_MEM_WDATA = I_P_WDATA;
            end
            d_gnt: begin
                O_MEM_WE    = I_D_WE;
                O_MEM_ADDR  = I_D_ADDR;
                O_MEM_WDATA = I_D_WDATA;
            end
            default: ;
        endcase
    end

    // Response tag: remembers who owns next cycle's read data.
    always_ff @(negedge I_CLOCK or negedge I_RESET_N) begin
        if (!I_RESET_N) begin
            state_q <= DARB_IDLE;
        end else begin
            unique case (1'b1)
                (p_gnt && !I_P_WE): state_q <= DARB_RESP_P;
                (d_gnt && !I_D_WE): state_q <= DARB_RESP_D;
                default:            state_q <= DARB_IDLE;
            endcase
        end
    end

    assign O_P_RVALID = (state_q == DARB_RESP_P);
    assign O_D_RVALID = (state_q == DARB_RESP_D);
    assign O_P_RDATA  = O_P_RVALID ? I_MEM_RDATA : '0;
    assign O_D_RDATA  = O_D_RVALID ? I_MEM_RDATA : '0;

`ifdef DMEM_ARB_STATS_EN
    logic [15:0] conflict_q;

    // Count cycles in which both ports contend.
    always_ff @(negedge I_CLOCK or negedge I_RESET_N) begin
        if (!I_RESET_N)
            conflict_q <= '0;
        else if (I_P_REQ && I_D_REQ)
            conflict_q <= sat_inc16(conflict_q);
    end

    assign O_CONFLICT_CNT = conflict_q;
`endif

endmodule
